regfile_mp: RTL

- Parametrised multi-port register file; next generation of the single-cycle CPU's 2-read/1-write register file.
- Serves pipelined and dual-issue datapaths.
- Adds a configurable number of read ports and two prioritised write ports.
- Adds an optional same-cycle write-to-read bypass, a hardwired-zero register, and a per-register busy scoreboard for hazard detection on long-latency writes (loads, multiply/divide).

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_rd_port.sv | 53 +++++
 rtl/regfile_mp.sv | 106 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry,
// the hardwired-zero address and write-port priority indices.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int REG_ZERO = 0;

  // Two write ports; on an address collision the higher index wins.
  localparam int NUM_WR = 2;
  localparam int WR_LO  = 0;
  localparam int WR_HI  = 1;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: committed contents, optional same-cycle
// write forwarding with port-1 priority, and the hardwired-zero override.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]    rd_addr_i,
  input  logic [DATA_W-1:0]    regs_i [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy_i,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [ADDR_W-1:0]    wr_addr_i [NUM_WR],
  input  logic [DATA_W-1:0]    wr_data_i [NUM_WR],
  input  logic                 mark_en_i,
  input  logic [ADDR_W-1:0]    mark_addr_i,
  output logic [DATA_W-1:0]    rd_data_o,
  output logic                 rd_busy_o
);

  logic hit_lo;
  logic hit_hi;
  logic hit_mark;
  logic is_zero;

  assign hit_lo   = wr_en_i[WR_LO] && (wr_addr_i[WR_LO] == rd_addr_i);
  assign hit_hi   = wr_en_i[WR_HI] && (wr_addr_i[WR_HI] == rd_addr_i);
  assign hit_mark = mark_en_i && (mark_addr_i == rd_addr_i);
  assign is_zero  = (ZERO_REG != 0) && (rd_addr_i == ADDR_W'(REG_ZERO));

  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    rd_busy_o = busy_i[rd_addr_i];
    if (BYPASS != 0) begin
      if (hit_hi) begin
        rd_data_o = wr_data_i[WR_HI];
      end else if (hit_lo) begin
        rd_data_o = wr_data_i[WR_LO];
      end
      // A forwarded write retires the old producer; only a same-cycle mark keeps it busy.
      if (hit_hi || hit_lo) begin
        rd_busy_o = hit_mark;
      end
    end
    if (is_zero) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, per-register
// busy scoreboard and NUM_RD combinational read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdBusy,
  input  logic [NUM_WR-1:0]        WrEn,
  input  logic [NUM_WR*ADDR_W-1:0] WrAddr,
  input  logic [NUM_WR*DATA_W-1:0] WrData,
  input  logic                     MarkEn,
  input  logic [ADDR_W-1:0]        MarkAddr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  logic [NUM_WR-1:0] wr_en;
  logic [ADDR_W-1:0] wr_addr [NUM_WR];
  logic [DATA_W-1:0] wr_data [NUM_WR];
  logic              mark_en;

  // Gate with reset so nothing is forwarded to the read ports while held in reset.
  assign wr_en   = WrEn & {NUM_WR{Rst_n}};
  assign mark_en = MarkEn & Rst_n;

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
    assign wr_addr[gi] = WrAddr[gi*ADDR_W +: ADDR_W];
    assign wr_data[gi] = WrData[gi*DATA_W +: DATA_W];
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    if ((ZERO_REG != 0) && (gi == REG_ZERO)) begin : g_zero
      assign regs_q[gi] = '0;
      assign busy_q[gi] = 1'b0;
    end else begin : g_live
      logic [DATA_W-1:0] data_q;
      logic [DATA_W-1:0] data_d;
      logic              busy_bit_q;
      logic              busy_bit_d;
      logic              hit_lo;
      logic              hit_hi;
      logic              hit_mark;

      assign hit_lo   = wr_en[WR_LO] && (wr_addr[WR_LO] == ADDR_W'(gi));
      assign hit_hi   = wr_en[WR_HI] && (wr_addr[WR_HI] == ADDR_W'(gi));
      assign hit_mark = mark_en && (MarkAddr == ADDR_W'(gi));

      always_comb begin
        data_d = data_q;
        if (hit_hi) begin
          data_d = wr_data[WR_HI];
        end else if (hit_lo) begin
          data_d = wr_data[WR_LO];
        end
        // A mark in the same cycle as the retiring write belongs to a new producer.
        busy_bit_d = (busy_bit_q && !(hit_lo || hit_hi)) || hit_mark;
      end

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          data_q     <= '0;
          busy_bit_q <= 1'b0;
        end else begin
          data_q     <= data_d;
          busy_bit_q <= busy_bit_d;
        end
      end

      assign regs_q[gi] = data_q;
      assign busy_q[gi] = busy_bit_q;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd_port (
      .rd_addr_i  (RdAddr[gi*ADDR_W +: ADDR_W]),
      .regs_i     (regs_q),
      .busy_i     (busy_q),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .mark_en_i  (mark_en),
      .mark_addr_i(MarkAddr),
      .rd_data_o  (RdData[gi*DATA_W +: DATA_W]),
      .rd_busy_o  (RdBusy[gi])
    );
  end

endmodule
